// File: rtl/power_gate_ctrl.sv
// rtl/power_gate_ctrl.sv - per-peripheral power-gating FSMs (drain, isolate, power-off, wake)
// Optional OFF-entry statistics counters are built when PWR_GATE_STATS_EN is defined.
module power_gate_ctrl #(
    parameter int N             = 4,
    parameter int W             = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0][W-1:0]   idle_count,
    input  logic [N-1:0]          recent_activity,
    input  logic [W-1:0]          idle_threshold,
    input  logic [N-1:0]          wake_req,
    input  logic [N-1:0]          sleep_ack,
    output logic [N-1:0]          periph_en,
    output logic [N-1:0]          sleep_req,
    output logic [N-1:0]          iso_en,
    output logic [N-1:0]          pwr_en,
    output logic [N-1:0][2:0]     pwr_state,
    output logic [N-1:0][7:0]     gate_count
);

    localparam logic [2:0] ST_RUN     = 3'd0;
    localparam logic [2:0] ST_DRAIN   = 3'd1;
    localparam logic [2:0] ST_ISOLATE = 3'd2;
    localparam logic [2:0] ST_OFF     = 3'd3;
    localparam logic [2:0] ST_POWERUP = 3'd4;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    logic gating_enabled;
    assign gating_enabled = (idle_threshold != '0);

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [2:0] state;
        logic [7:0] settle_cnt;
        logic       gate_ok;
        logic       abort;
        logic       enter_off;

        assign gate_ok = gating_enabled
                      && (idle_count[i] >= idle_threshold)
                      && !recent_activity[i]
                      && !wake_req[i];

        assign abort = wake_req[i] || recent_activity[i];

        // Wake takes priority over the settle timeout, so a late wake never lets power drop.
        assign enter_off = (state == ST_ISOLATE) && !wake_req[i] && (settle_cnt == 8'd0);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state      <= ST_RUN;
                settle_cnt <= 8'd0;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (gate_ok) begin
                            state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (abort) begin
                            state <= ST_RUN;
                        end else if (sleep_ack[i]) begin
                            state      <= ST_ISOLATE;
                            settle_cnt <= SETTLE_LOAD;
                        end
                    end
                    ST_ISOLATE: begin
                        if (wake_req[i]) begin
                            state      <= ST_POWERUP;
                            settle_cnt <= SETTLE_LOAD;
                        end else if (settle_cnt == 8'd0) begin
                            state <= ST_OFF;
                        end else begin
                            settle_cnt <= settle_cnt - 8'd1;
                        end
                    end
                    ST_OFF: begin
                        if (wake_req[i]) begin
                            state      <= ST_POWERUP;
                            settle_cnt <= SETTLE_LOAD;
                        end
                    end
                    ST_POWERUP: begin
                        if (settle_cnt == 8'd0) begin
                            state <= ST_RUN;
                        end else begin
                            settle_cnt <= settle_cnt - 8'd1;
                        end
                    end
                    default: begin
                        state      <= ST_RUN;
                        settle_cnt <= 8'd0;
                    end
                endcase
            end
        end

        always_comb begin
            periph_en[i] = 1'b1;
            sleep_req[i] = 1'b0;
            iso_en[i]    = 1'b0;
            pwr_en[i]    = 1'b1;
            case (state)
                ST_RUN: begin
                    periph_en[i] = 1'b1;
                end
                ST_DRAIN: begin
                    sleep_req[i] = 1'b1;
                end
                ST_ISOLATE, ST_POWERUP: begin
                    periph_en[i] = 1'b0;
                    iso_en[i]    = 1'b1;
                end
                ST_OFF: begin
                    periph_en[i] = 1'b0;
                    iso_en[i]    = 1'b1;
                    pwr_en[i]    = 1'b0;
                end
                default: begin
                    periph_en[i] = 1'b1;
                end
            endcase
        end

        assign pwr_state[i] = state;

`ifdef PWR_GATE_STATS_EN
        logic [7:0] off_entries;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                off_entries <= 8'd0;
            end else if (enter_off && (off_entries != 8'hFF)) begin
                off_entries <= off_entries + 8'd1;
            end
        end

        assign gate_count[i] = off_entries;
`else
        logic unused_enter_off;
        assign unused_enter_off = enter_off;
        assign gate_count[i]    = 8'd0;
`endif
    end

endmodule

// File: tb/tb_power_gate_ctrl.sv
// tb/tb_power_gate_ctrl.sv - table-driven scoreboard bench for power_gate_ctrl
module tb_power_gate_ctrl;

    localparam int N = 4;
    localparam int W = 16;
`ifdef PWR_GATE_STATS_EN
    localparam logic [7:0] STATS = 8'd1;
`else
    localparam logic [7:0] STATS = 8'd0;
`endif

    localparam logic [2:0] RUN = 3'd0, DRAIN = 3'd1, ISO = 3'd2, OFF = 3'd3, PU = 3'd4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0][W-1:0] idle_count;
    logic [N-1:0]        recent_activity;
    logic [W-1:0]        idle_threshold;
    logic [N-1:0]        wake_req;
    logic [N-1:0]        sleep_ack;
    logic [N-1:0]        periph_en;
    logic [N-1:0]        sleep_req;
    logic [N-1:0]        iso_en;
    logic [N-1:0]        pwr_en;
    logic [N-1:0][2:0]   pwr_state;
    logic [N-1:0][7:0]   gate_count;

    always #5 clk = ~clk;

    power_gate_ctrl #(.N(N), .W(W), .SETTLE_CYCLES(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .idle_count      (idle_count),
        .recent_activity (recent_activity),
        .idle_threshold  (idle_threshold),
        .wake_req        (wake_req),
        .sleep_ack       (sleep_ack),
        .periph_en       (periph_en),
        .sleep_req       (sleep_req),
        .iso_en          (iso_en),
        .pwr_en          (pwr_en),
        .pwr_state       (pwr_state),
        .gate_count      (gate_count)
    );

    typedef struct packed {
        logic                rst;
        logic [W-1:0]        thr;
        logic [N-1:0][W-1:0] idle;
        logic [N-1:0]        act;
        logic [N-1:0]        wake;
        logic [N-1:0]        ack;
        logic [N-1:0][2:0]   est;
        logic [N-1:0][7:0]   egc;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    logic                c_rst;
    logic [W-1:0]        c_thr;
    logic [N-1:0][W-1:0] c_idle;
    logic [N-1:0]        c_act, c_wake, c_ack;
    logic [N-1:0][2:0]   st;
    logic [N-1:0][7:0]   gc_m;

    int n_vec = 0;
    int n_err = 0;

    task automatic add(input int reps);
        for (int r = 0; r < reps; r++)
            tbl.push_back({c_rst, c_thr, c_idle, c_act, c_wake, c_ack, st, gc_m});
    endtask

    task automatic check(input int idx);
        vec_t e;
        logic [N-1:0] e_pen, e_sreq, e_iso, e_pwr;
        e = sb.pop_front();
        for (int p = 0; p < N; p++) begin
            e_pen[p]  = (e.est[p] == RUN) || (e.est[p] == DRAIN);
            e_sreq[p] = (e.est[p] == DRAIN);
            e_iso[p]  = (e.est[p] == ISO) || (e.est[p] == OFF) || (e.est[p] == PU);
            e_pwr[p]  = (e.est[p] != OFF);
        end
        n_vec++;
        if (pwr_state !== e.est || periph_en !== e_pen || sleep_req !== e_sreq ||
            iso_en !== e_iso || pwr_en !== e_pwr || gate_count !== e.egc) begin
            n_err++;
            $display("FAIL vec%0d: got state=%h pen=%b sreq=%b iso=%b pwr=%b gc=%h, expected state=%h pen=%b sreq=%b iso=%b pwr=%b gc=%h",
                     idx, pwr_state, periph_en, sleep_req, iso_en, pwr_en, gate_count,
                     e.est, e_pen, e_sreq, e_iso, e_pwr, e.egc);
        end
    endtask

    initial begin
        rst_n = 1'b0; idle_count = '0; recent_activity = '0;
        idle_threshold = '0; wake_req = '0; sleep_ack = '0;

        // Reset, with inputs that would otherwise gate immediately.
        c_rst = 1'b0; c_thr = 16'd1; c_idle = {N{16'hFFFF}};
        c_act = '0; c_wake = '0; c_ack = '0; st = '0; gc_m = '0;
        add(2);
        c_rst = 1'b1; c_thr = 16'd10; c_idle = '0;
        add(1);

        // Peripheral 0: idle ramp, drain, isolate, off, wake.
        for (int v = 1; v <= 9; v++) begin
            c_idle[0] = 16'(v);
            add(1);
        end
        c_idle[0] = 16'd10; st[0] = DRAIN; add(1);
        c_idle[0] = 16'd11; add(1);
        c_ack[0] = 1'b1; st[0] = ISO; add(1);
        c_ack[0] = 1'b0; c_idle[0] = '0; add(3);
        st[0] = OFF; gc_m[0] = STATS; add(1);
        c_ack[0] = 1'b1; add(1);
        c_ack[0] = 1'b0; add(1);
        c_wake[0] = 1'b1; st[0] = PU; add(1);
        c_wake[0] = 1'b0; add(3);
        st[0] = RUN; add(2);

        // Peripheral 1: wake+ack abort, then recent_activity abort.
        c_idle[1] = 16'd10; st[1] = DRAIN; add(1);
        c_wake[1] = 1'b1; c_ack[1] = 1'b1; st[1] = RUN; add(1);
        c_wake[1] = 1'b0; c_ack[1] = 1'b0; c_idle[1] = 16'd12; st[1] = DRAIN; add(1);
        c_act[1] = 1'b1; c_ack[1] = 1'b1; st[1] = RUN; add(1);
        c_act[1] = 1'b0; c_ack[1] = 1'b0; c_idle[1] = '0; add(1);

        // Threshold 0 disables gating; stray acks in RUN are ignored.
        c_thr = '0; c_idle = {N{16'hFFFF}}; add(1);
        c_ack = '1; add(1);
        c_ack = '0; add(8);
        // Saturated count against all-ones threshold gates every peripheral at once.
        c_thr = 16'hFFFF; st = {N{DRAIN}}; add(1);
        c_act = '1; st = '0; add(1);
        c_act = '0; c_idle = '0; c_thr = 16'd10; add(1);

        // Peripheral 2: wake on ISOLATE cycle 2, power never drops.
        c_idle[2] = 16'd10; st[2] = DRAIN; add(1);
        c_ack[2] = 1'b1; st[2] = ISO; add(1);
        c_ack[2] = 1'b0; c_idle[2] = '0; add(1);
        c_wake[2] = 1'b1; st[2] = PU; add(2);
        c_wake[2] = 1'b0; add(2);
        st[2] = RUN; add(1);

        // Peripheral 3: reach OFF, then reset restores power with no settle.
        c_idle[3] = 16'd10; st[3] = DRAIN; add(1);
        c_ack[3] = 1'b1; st[3] = ISO; add(1);
        c_ack[3] = 1'b0; c_idle[3] = '0; add(3);
        st[3] = OFF; gc_m[3] = STATS; add(1);
        c_rst = 1'b0; st = '0; gc_m = '0; add(1);
        c_rst = 1'b1; add(2);

        foreach (tbl[k]) begin
            @(negedge clk);
            rst_n           = tbl[k].rst;
            idle_threshold  = tbl[k].thr;
            idle_count      = tbl[k].idle;
            recent_activity = tbl[k].act;
            wake_req        = tbl[k].wake;
            sleep_ack       = tbl[k].ack;
            sb.push_back(tbl[k]);
            @(posedge clk);
            #1;
            check(k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/power_gate_ctrl.md
# power_gate_ctrl

Per-peripheral power-gating controller that consumes the idle-tracking outputs of the activity counter (`idle_count`, `recent_activity`) and drives its `periph_en` inputs in return. When a peripheral has been idle for a programmable number of cycles, the controller performs a drain handshake with it, isolates it and removes power. On a wake request it restores power and isolation in reverse order and re-enables the peripheral. The block sits between the activity counter and the power switches/isolation cells of the N peripherals.

## Interface
- `N`, 4, number of peripherals (matches the activity counter)
- `W`, 16, idle-count width (matches the activity counter)
- `SETTLE_CYCLES`, 4, cycles spent in ISOLATE and POWERUP; legal range 1..255
- `clk` input 1: single clock.
- `rst_n` input 1: reset, synchronous and active-low.
- `idle_count` input [N-1:0][W-1:0]: per-peripheral idle cycle count from the activity counter.
- `recent_activity` input [N-1:0]: per-peripheral recent-activity flag.
- `idle_threshold` input [W-1:0]: shared idle threshold; 0 disables gating for all peripherals.
- `wake_req` input [N-1:0]: level wake request per peripheral.
- `sleep_ack` input [N-1:0]: peripheral acknowledges it has drained.
- `periph_en` output [N-1:0]: enable to peripheral and activity counter.
- `sleep_req` output [N-1:0]: drain request to peripheral.
- `iso_en` output [N-1:0]: isolation-cell enable, active-high.
- `pwr_en` output [N-1:0]: power-switch enable, active-high.
- `pwr_state` output [N-1:0][2:0]: per-peripheral FSM state: RUN=0, DRAIN=1, ISOLATE=2, OFF=3, POWERUP=4.
- `gate_count` output [N-1:0][7:0]: OFF-entry counter (see Configuration).

## Operation
- N independent Moore FSMs, each with an 8-bit settle counter. All outputs are decoded from registered state, and no input reaches an output combinationally.
- Output decode per state (periph_en / sleep_req / iso_en / pwr_en):
  - RUN: 1/0/0/1
  - DRAIN: 1/1/0/1
  - ISOLATE: 0/0/1/1
  - OFF: 0/0/1/0
  - POWERUP: 0/0/1/1
- Define `gate_ok[i]` = (`idle_threshold` != 0) && (`idle_count[i]` >= `idle_threshold`) && !`recent_activity[i]` && !`wake_req[i]`. The comparison is unsigned and W bits wide.
- Transitions:
  - RUN -> DRAIN when `gate_ok[i]`.
  - DRAIN -> RUN when `wake_req[i]` or `recent_activity[i]`. This abort has priority over `sleep_ack`.
  - DRAIN -> ISOLATE when `sleep_ack[i]` and no abort. The settle counter loads SETTLE_CYCLES-1.
  - ISOLATE -> POWERUP when `wake_req[i]`. The settle counter reloads SETTLE_CYCLES-1.
  - ISOLATE -> OFF when the counter reaches 0. Otherwise the counter decrements each cycle.
  - OFF -> POWERUP when `wake_req[i]`. The counter loads SETTLE_CYCLES-1.
  - POWERUP -> RUN when the counter reaches 0. `wake_req` is ignored in POWERUP.
- `sleep_ack` is ignored in every state except DRAIN.
- De-asserting `periph_en` in ISOLATE clears the activity counter's idle count. As a result, RUN is always re-entered with the idle count restarting from 0, and an immediate re-gate cannot occur.
- Peripherals never interact; simultaneous events on different indices are handled independently in the same cycle.

## Timing
- Reset (`rst_n`=0 at a rising edge), for every i:
  - state = RUN and settle counter = 0.
  - `periph_en`=1, `pwr_en`=1, `iso_en`=0, `sleep_req`=0, `pwr_state`=0, `gate_count`=0.
- Reset applied mid-sequence (any state, including OFF) forces RUN at that edge. Power is restored immediately, with no POWERUP settle.
- `gate_ok` true at edge k: `sleep_req` is high after edge k.
- `sleep_ack` high at edge k: `iso_en`=1 and `periph_en`=0 after edge k.
- ISOLATE lasts exactly SETTLE_CYCLES cycles; `pwr_en` falls after the SETTLE_CYCLES-th edge.
- `wake_req` high at edge k in OFF: `pwr_en`=1 after edge k.
- POWERUP lasts exactly SETTLE_CYCLES cycles, then `iso_en`=0 and `periph_en`=1 together.
- End-to-end latency:
  - Sleep: 1 + ack latency + SETTLE_CYCLES edges.
  - Wake from OFF: 1 + SETTLE_CYCLES edges.
- `idle_threshold` changes take effect on the next edge.
- `idle_count` saturated at all-ones still satisfies the comparison.

## Configuration
- Macro: `PWR_GATE_STATS_EN`.
- Defined: `gate_count[i]` increments by 1 on each ISOLATE->OFF transition and saturates at 255. It is cleared only by reset.
- Undefined: `gate_count` is tied to 0 and no counter flops are instantiated. All other behaviour is identical.

## Test plan
- Sleep entry (threshold=10, `idle_count[0]` ramps 0..10 with `recent_activity`=0): `sleep_req[0]`=1 after the edge where count=10. Then `sleep_ack[0]`=1 gives ISOLATE for 4 cycles, then OFF with `pwr_en[0]`=0, `iso_en[0]`=1, `pwr_state[0]`=3.
- Wake (in OFF, pulse `wake_req[0]` for 1 cycle): `pwr_en[0]`=1 next cycle, `iso_en[0]` held 1 for 4 cycles, then `periph_en[0]`=1, `iso_en[0]`=0, `pwr_state[0]`=0. With stats enabled, `gate_count[0]`=1.
- Drain abort (in DRAIN, assert `wake_req[1]` and `sleep_ack[1]` in the same cycle): state returns to RUN, `sleep_req[1]`=0, `iso_en[1]` stays 0, `pwr_en[1]` stays 1.
- Disable and ignore (threshold=0 with `idle_count`=FFFF on all peripherals): all stay in RUN indefinitely. A `sleep_ack` pulse in RUN has no effect.
- Wake during ISOLATE (`wake_req[2]` on ISOLATE cycle 2): POWERUP for exactly 4 cycles, then RUN. `pwr_en[2]` never drops.
- Reset in OFF (peripheral 3 in OFF, `rst_n`=0 for 1 edge): `pwr_en[3]`=1, `iso_en[3]`=0, `periph_en[3]`=1, `gate_count`=0 immediately after that edge.
